// File: rtl/usb_std_request_handler.sv
// EP0 standard-request responder: collects 8 SETUP bytes, decodes, streams IN data (ROM or constant), STALLs bad requests.
// One IN byte per >=3 cycles; inData held while inValid && !inReady; address/config applied only on statusDone.
module usb_std_request_handler #(
  parameter int DEV_DESC_LEN  = 18,
  parameter int CONF_DESC_LEN = 32,
  parameter int CONF_VALUE    = 1,
  parameter int SELF_POWERED  = 0,
  parameter int ROM_AW        = 8
) (
  input  logic              clk48,
  input  logic              rstn,
  input  logic              usbReset,
  input  logic              setupStart,
  input  logic              setupValid,
  input  logic [7:0]        setupData,
  output logic              inValid,
  output logic [7:0]        inData,
  output logic              inLast,
  input  logic              inReady,
  input  logic              statusDone,
  output logic              reqError,
  output logic [ROM_AW-1:0] romAddr,
  input  logic [7:0]        romData,
  output logic [6:0]        devAddr,
  output logic              devConfigured
);

  typedef enum logic [2:0] {
    S_IDLE, S_RECV, S_DECODE, S_FETCH, S_FETCH_WAIT, S_DATA, S_WAIT_STATUS, S_STALL
  } state_t;

  state_t            r_state, w_next;
  logic [7:0]        r_setup [8];
  logic [2:0]        r_cnt;
  logic [15:0]       r_idx, r_resp_len;
  logic [ROM_AW-1:0] r_base, r_rom_addr;
  logic              r_src_rom;
  logic [7:0]        r_const0, r_in_data;
  logic [6:0]        r_dev_addr, r_pend_addr;
  logic              r_pend_addr_vld, r_pend_cfg_vld;
  logic [7:0]        r_config, r_pend_cfg;

  logic              w_dir_in;
  logic [1:0]        w_type;
  logic [4:0]        w_recip;
  logic [7:0]        w_breq;
  logic [15:0]       w_wvalue, w_wlength;
  logic              w_stall, w_src_rom, w_set_addr, w_set_cfg, w_last;
  logic [15:0]       w_item_len, w_resp_len;
  logic [ROM_AW-1:0] w_base;
  logic [7:0]        w_const0;

  assign w_dir_in  = r_setup[0][7];
  assign w_type    = r_setup[0][6:5];
  assign w_recip   = r_setup[0][4:0];
  assign w_breq    = r_setup[1];
  assign w_wvalue  = {r_setup[3], r_setup[2]};
  assign w_wlength = {r_setup[7], r_setup[6]};
  assign w_last    = (r_idx == r_resp_len - 16'd1);

  // Request decode; anything not explicitly accepted below is a STALL.
  always_comb begin
    w_stall    = 1'b1;
    w_item_len = 16'd0;
    w_src_rom  = 1'b0;
    w_base     = '0;
    w_const0   = 8'h00;
    w_set_addr = 1'b0;
    w_set_cfg  = 1'b0;
    if (w_type == 2'd0) begin
      case (w_breq)
        8'd0: if (w_dir_in && w_recip <= 5'd2) begin
          w_stall    = 1'b0;
          w_item_len = 16'd2;
          w_const0   = (w_recip == 5'd0) ? 8'(SELF_POWERED) : 8'h00;
        end
        8'd8: if (w_dir_in) begin
          w_stall    = 1'b0;
          w_item_len = 16'd1;
          w_const0   = r_config;
        end
        8'd6: if (w_dir_in && w_wvalue == 16'h0100) begin
          w_stall    = 1'b0;
          w_src_rom  = 1'b1;
          w_item_len = 16'(DEV_DESC_LEN);
        end else if (w_dir_in && w_wvalue == 16'h0200) begin
          w_stall    = 1'b0;
          w_src_rom  = 1'b1;
          w_base     = ROM_AW'(DEV_DESC_LEN);
          w_item_len = 16'(CONF_DESC_LEN);
        end
        8'd5: if (!w_dir_in && w_wvalue <= 16'd127 && r_config == 8'd0) begin
          w_stall    = 1'b0;
          w_set_addr = 1'b1;
        end
        8'd9: if (!w_dir_in && (w_wvalue == 16'd0 || w_wvalue == 16'(CONF_VALUE))
                  && r_dev_addr != 7'd0) begin
          w_stall   = 1'b0;
          w_set_cfg = 1'b1;
        end
        default: ;
      endcase
    end
    w_resp_len = (w_item_len < w_wlength) ? w_item_len : w_wlength;
  end

  always_comb begin
    w_next = r_state;
    if (setupStart) begin
      w_next = S_RECV;
    end else begin
      case (r_state)
        S_IDLE:        ;
        S_RECV:        if (setupValid && r_cnt == 3'd7) w_next = S_DECODE;
        S_DECODE: begin
          if (w_stall)                   w_next = S_STALL;
          else if (w_resp_len == 16'd0)  w_next = S_WAIT_STATUS;
          else                           w_next = S_FETCH;
        end
        S_FETCH:       w_next = S_FETCH_WAIT;
        S_FETCH_WAIT:  w_next = S_DATA;
        S_DATA:        if (inReady) w_next = w_last ? S_WAIT_STATUS : S_FETCH;
        S_WAIT_STATUS: if (statusDone) w_next = S_IDLE;
        S_STALL:       ;
        default:       w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk48 or negedge rstn) begin
    if (!rstn)         r_state <= S_IDLE;
    else if (usbReset) r_state <= S_IDLE;
    else               r_state <= w_next;
  end

  always_ff @(posedge clk48 or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 8; i++) r_setup[i] <= 8'h00;
      r_cnt <= '0; r_idx <= '0; r_resp_len <= '0; r_base <= '0; r_rom_addr <= '0;
      r_src_rom <= 1'b0; r_const0 <= '0; r_in_data <= '0;
      r_dev_addr <= '0; r_pend_addr <= '0; r_pend_addr_vld <= 1'b0;
      r_config <= '0; r_pend_cfg <= '0; r_pend_cfg_vld <= 1'b0;
    end else if (usbReset) begin
      r_cnt <= '0; r_idx <= '0; r_rom_addr <= '0; r_in_data <= '0;
      r_dev_addr <= '0; r_pend_addr_vld <= 1'b0;
      r_config <= '0; r_pend_cfg_vld <= 1'b0;
    end else if (setupStart) begin
      r_cnt           <= '0;
      r_pend_addr_vld <= 1'b0;
      r_pend_cfg_vld  <= 1'b0;
    end else begin
      case (r_state)
        S_RECV: if (setupValid) begin
          r_setup[r_cnt] <= setupData;
          r_cnt          <= r_cnt + 3'd1;
        end
        S_DECODE: begin
          r_resp_len <= w_resp_len;
          r_idx      <= '0;
          r_base     <= w_base;
          r_src_rom  <= w_src_rom;
          r_const0   <= w_const0;
          if (!w_stall) begin
            r_pend_addr_vld <= w_set_addr;
            r_pend_addr     <= w_wvalue[6:0];
            r_pend_cfg_vld  <= w_set_cfg;
            r_pend_cfg      <= w_wvalue[7:0];
            if (w_src_rom) r_rom_addr <= w_base;
          end
        end
        // ROM output is registered, so it is valid here, one cycle after FETCH presented the address.
        S_FETCH_WAIT: r_in_data <= r_src_rom ? romData : ((r_idx == 16'd0) ? r_const0 : 8'h00);
        S_DATA: if (inReady) begin
          r_idx <= r_idx + 16'd1;
          if (!w_last && r_src_rom) r_rom_addr <= r_base + ROM_AW'(r_idx + 16'd1);
        end
        S_WAIT_STATUS: if (statusDone) begin
          if (r_pend_addr_vld) r_dev_addr <= r_pend_addr;
          if (r_pend_cfg_vld)  r_config   <= r_pend_cfg;
          r_pend_addr_vld <= 1'b0;
          r_pend_cfg_vld  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign inValid       = (r_state == S_DATA);
  assign inLast        = inValid && w_last;
  assign inData        = r_in_data;
  assign reqError      = (r_state == S_STALL);
  assign romAddr       = r_rom_addr;
  assign devAddr       = r_dev_addr;
  assign devConfigured = (r_config != 8'd0);

endmodule

// File: tb/tb_usb_std_request_handler.sv
// Bench for usb_std_request_handler: directed SETUP scenarios plus random requests vs a request-level model.
module tb_usb_std_request_handler;
  localparam int DEV_LEN  = 18;
  localparam int CONF_LEN = 32;

  logic       clk48 = 1'b0, rstn = 1'b0, usbReset = 1'b0;
  logic       setupStart = 1'b0, setupValid = 1'b0;
  logic [7:0] setupData = 8'h00;
  logic       inValid, inLast, reqError, devConfigured;
  logic [7:0] inData, romAddr, romData;
  logic       inReady = 1'b0, statusDone = 1'b0;
  logic [6:0] devAddr;
  logic [7:0] rom [256];

  int n_checks = 0, n_fail = 0;
  int m_addr = 0, m_cfg = 0;

  always #10 clk48 = ~clk48;
  always @(posedge clk48) romData <= rom[romAddr];

  usb_std_request_handler dut (
    .clk48(clk48), .rstn(rstn), .usbReset(usbReset), .setupStart(setupStart),
    .setupValid(setupValid), .setupData(setupData), .inValid(inValid), .inData(inData),
    .inLast(inLast), .inReady(inReady), .statusDone(statusDone), .reqError(reqError),
    .romAddr(romAddr), .romData(romData), .devAddr(devAddr), .devConfigured(devConfigured)
  );

  // Request-level model: what the host should see for this SETUP given current device state.
  task automatic model(input logic [7:0] s [8], output bit stall, output int exp_q[$],
                       output int na, output int nc);
    int rt, req, wv, wl, recip;
    bit dir_in;
    int item[$];
    rt = s[0]; req = s[1]; wv = s[2] + 256 * s[3]; wl = s[6] + 256 * s[7];
    dir_in = (rt >= 128); recip = rt % 32;
    stall = 1; na = m_addr; nc = m_cfg; item = {}; exp_q = {};
    if ((rt / 32) % 4 == 0) begin
      if (req == 0 && dir_in && recip <= 2) begin
        stall = 0; item.push_back(recip == 0 ? 0 : 0); item.push_back(0);
      end else if (req == 8 && dir_in) begin
        stall = 0; item.push_back(m_cfg);
      end else if (req == 6 && dir_in && wv == 16'h0100) begin
        stall = 0; for (int i = 0; i < DEV_LEN; i++) item.push_back(rom[i]);
      end else if (req == 6 && dir_in && wv == 16'h0200) begin
        stall = 0; for (int i = 0; i < CONF_LEN; i++) item.push_back(rom[DEV_LEN + i]);
      end else if (req == 5 && !dir_in && wv <= 127 && m_cfg == 0) begin
        stall = 0; na = wv;
      end else if (req == 9 && !dir_in && (wv == 0 || wv == 1) && m_addr != 0) begin
        stall = 0; nc = wv;
      end
    end
    for (int i = 0; i < item.size() && i < wl; i++) exp_q.push_back(item[i]);
  endtask

  task automatic send_setup(input logic [7:0] s [8], input bit gaps, input bit wait_first);
    if (wait_first) @(negedge clk48);
    setupStart = 1'b1;
    @(negedge clk48);
    setupStart = 1'b0;
    n_checks++;
    if (inValid !== 1'b0 || reqError !== 1'b0) begin
      n_fail++;
      $display("FAIL setup_clear: inValid=%b reqError=%b, need 0/0", inValid, reqError);
    end
    for (int i = 0; i < 8; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        setupValid = 1'b0; @(negedge clk48);
      end
      setupValid = 1'b1; setupData = s[i];
      @(negedge clk48);
    end
    setupValid = 1'b0;
    @(negedge clk48);
  endtask

  // Accept n_take bytes with random inReady; checks data, inLast position and hold-while-stalled.
  task automatic collect(input int exp_q[$], input string nm, input int rdy_pct, input int n_take);
    int got, cyc;
    bit held;
    logic [7:0] held_dat;
    got = 0; cyc = 0; held = 0; held_dat = 8'h00;
    if (n_take == 0) begin
      n_checks++;
      if (inValid !== 1'b0) begin
        n_fail++; $display("FAIL %s no_data: inValid=%b, need 0", nm, inValid);
      end
      return;
    end
    while (got < n_take && cyc < 2000) begin
      if (held) begin
        n_checks++;
        if (inValid !== 1'b1 || inData !== held_dat) begin
          n_fail++;
          $display("FAIL %s hold: inValid=%b inData=%h, need 1/%h", nm, inValid, inData, held_dat);
        end
      end
      inReady = ($urandom_range(0, 99) < rdy_pct);
      held = 0;
      if (inValid === 1'b1) begin
        if (inReady) begin
          n_checks++;
          if (inData !== 8'(exp_q[got]) || inLast !== (got == exp_q.size() - 1)) begin
            n_fail++;
            $display("FAIL %s byte%0d: data=%h last=%b, need %h/%b", nm, got, inData, inLast,
                     8'(exp_q[got]), (got == exp_q.size() - 1));
          end
          got++;
        end else begin
          held = 1; held_dat = inData;
        end
      end
      @(negedge clk48);
      cyc++;
    end
    inReady = 1'b0;
    n_checks++;
    if (got != n_take) begin
      n_fail++; $display("FAIL %s count: got %0d bytes, need %0d", nm, got, n_take);
    end
    if (n_take == exp_q.size()) begin
      repeat (4) @(negedge clk48);
      n_checks++;
      if (inValid !== 1'b0) begin
        n_fail++; $display("FAIL %s extra: inValid=%b after last byte, need 0", nm, inValid);
      end
    end
  endtask

  task automatic run_req(input logic [7:0] s [8], input string nm, input int rdy_pct, input bit wait_first);
    bit stall;
    int exp_q[$];
    int na, nc;
    model(s, stall, exp_q, na, nc);
    send_setup(s, 1'b1, wait_first);
    n_checks++;
    if (reqError !== stall) begin
      n_fail++; $display("FAIL %s reqError: got %b, need %b", nm, reqError, stall);
    end
    if (!stall) collect(exp_q, nm, rdy_pct, exp_q.size());
    else repeat (3) @(negedge clk48);
    n_checks++;
    if (devAddr !== 7'(m_addr) || devConfigured !== (m_cfg != 0)) begin
      n_fail++;
      $display("FAIL %s pre_status: addr=%h cfg=%b, need %h/%b", nm, devAddr, devConfigured, 7'(m_addr), m_cfg != 0);
    end
    statusDone = 1'b1;
    @(negedge clk48);
    statusDone = 1'b0;
    if (!stall) begin m_addr = na; m_cfg = nc; end
    n_checks++;
    if (devAddr !== 7'(m_addr) || devConfigured !== (m_cfg != 0) || reqError !== stall) begin
      n_fail++;
      $display("FAIL %s post_status: addr=%h cfg=%b err=%b, need %h/%b/%b", nm, devAddr, devConfigured,
               reqError, 7'(m_addr), m_cfg != 0, stall);
    end
    @(negedge clk48);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk48);
    rstn = 1'b1;
    @(negedge clk48);
    n_checks++;
    if (inValid !== 0 || inLast !== 0 || reqError !== 0 || romAddr !== 0 || devAddr !== 0 || devConfigured !== 0) begin
      n_fail++;
      $display("FAIL reset: v=%b l=%b e=%b rom=%h addr=%h cfg=%b, need all 0", inValid, inLast, reqError,
               romAddr, devAddr, devConfigured);
    end
  endtask

  task automatic test_descriptors();
    logic [7:0] s [8];
    s = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00};
    run_req(s, "dev_desc", 100, 1'b1);
    s = '{8'h80, 8'h06, 8'h00, 8'h02, 8'h00, 8'h00, 8'h09, 8'h00};
    run_req(s, "conf_desc9", 40, 1'b1);
  endtask

  task automatic test_abort();
    logic [7:0] s [8];
    bit stall;
    int exp_q[$];
    int na, nc, cyc;
    s = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00};
    model(s, stall, exp_q, na, nc);
    send_setup(s, 1'b0, 1'b1);
    collect(exp_q, "abort_desc", 100, 4);
    cyc = 0;
    while (inValid !== 1'b1 && cyc < 10) begin @(negedge clk48); cyc++; end
    s = '{8'h80, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00};
    run_req(s, "abort_getcfg", 100, 1'b0);
    s = '{8'h00, 8'h05, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_setup(s, 1'b0, 1'b1);
    repeat (2) @(negedge clk48);
    s = '{8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00};
    run_req(s, "abort_getstatus", 70, 1'b1);
    n_checks++;
    if (devAddr !== 7'h00) begin
      n_fail++; $display("FAIL aborted_set_address: addr=%h, need 00", devAddr);
    end
  endtask

  task automatic test_set_address_config();
    logic [7:0] s [8];
    s = '{8'h00, 8'h05, 8'h2A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_req(s, "set_addr", 100, 1'b1);
    s = '{8'h00, 8'h09, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_req(s, "set_cfg", 100, 1'b1);
    s = '{8'h80, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00};
    run_req(s, "get_cfg", 100, 1'b1);
  endtask

  task automatic test_stall_bad_config();
    logic [7:0] s [8];
    s = '{8'h00, 8'h09, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_req(s, "set_cfg5", 100, 1'b1);
    s = '{8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00};
    run_req(s, "after_stall", 100, 1'b1);
  endtask

  task automatic test_usb_reset();
    @(negedge clk48);
    usbReset = 1'b1;
    @(negedge clk48);
    usbReset = 1'b0;
    m_addr = 0; m_cfg = 0;
    n_checks++;
    if (devAddr !== 7'h00 || devConfigured !== 1'b0 || inValid !== 1'b0 || reqError !== 1'b0) begin
      n_fail++;
      $display("FAIL usb_reset: addr=%h cfg=%b v=%b e=%b, need 0", devAddr, devConfigured, inValid, reqError);
    end
  endtask

  task automatic test_random();
    logic [7:0] s [8];
    int k, wv, wl;
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 9);
      s[0] = 8'h80; s[4] = 8'($urandom); s[5] = 8'($urandom);
      wv = 0; wl = $urandom_range(0, 3);
      case (k)
        0: begin s[0] = 8'(8'h80 + $urandom_range(0, 3)); s[1] = 8'd0; end
        1: s[1] = 8'd8;
        2: begin s[1] = 8'd6; wv = 256 * $urandom_range(1, 3) + ($urandom_range(0, 2) == 0); wl = $urandom_range(0, 40); end
        3: begin s[0] = 8'h00; s[1] = 8'd5; wv = $urandom_range(0, 140); wl = 0; end
        4: begin s[0] = 8'h00; s[1] = 8'd9; wv = $urandom_range(0, 2); wl = 0; end
        5: begin s[0] = ($urandom_range(0, 1) != 0) ? 8'hC0 : 8'h21; s[1] = 8'($urandom_range(0, 12)); end
        6: begin s[0] = 8'h00; s[1] = 8'($urandom_range(10, 255)); end
        default: begin s[1] = 8'd6; wv = ($urandom_range(0, 1) != 0) ? 16'h0100 : 16'h0200;
                       wl = ($urandom_range(0, 3) == 0) ? 16'h0100 + $urandom_range(0, 255) : $urandom_range(0, 36); end
      endcase
      s[2] = 8'(wv % 256); s[3] = 8'(wv / 256); s[6] = 8'(wl % 256); s[7] = 8'(wl / 256);
      run_req(s, "random", $urandom_range(30, 100), 1'b1);
    end
  endtask

  task automatic test_rstn_mid_recv();
    logic [7:0] s [8];
    test_usb_reset();
    s = '{8'h00, 8'h05, 8'h15, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_req(s, "set_addr15", 100, 1'b1);
    setupStart = 1'b1; @(negedge clk48); setupStart = 1'b0;
    for (int i = 0; i < 3; i++) begin setupValid = 1'b1; setupData = 8'h80; @(negedge clk48); end
    setupValid = 1'b0;
    rstn = 1'b0;
    #1;
    m_addr = 0; m_cfg = 0;
    n_checks++;
    if (inValid !== 0 || inLast !== 0 || reqError !== 0 || romAddr !== 0 || devAddr !== 0 || devConfigured !== 0) begin
      n_fail++;
      $display("FAIL rstn_mid_recv: v=%b l=%b e=%b rom=%h addr=%h cfg=%b, need all 0", inValid, inLast,
               reqError, romAddr, devAddr, devConfigured);
    end
    @(negedge clk48);
    rstn = 1'b1;
    s = '{8'h80, 8'h06, 8'h00, 8'h02, 8'h00, 8'h00, 8'hFF, 8'h00};
    run_req(s, "after_rstn", 60, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom_range(0, 255));
    test_reset();
    test_descriptors();
    test_abort();
    test_set_address_config();
    test_stall_bad_config();
    test_usb_reset();
    test_random();
    test_rstn_mid_recv();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
